// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through / no-write-allocate cache controller with one-word lines.
// Define CACHE_STATS_EN to enable saturating hit/miss counters; otherwise both counters read 0.
module cache_ctrl #(
   parameter int TAG_LENGTH   = 10,
   parameter int INDEX_LENGTH = 6,
   parameter int DATA_WIDTH   = 32
) (
   input  logic                               clk,
   input  logic                               resetn,
   input  logic                               cpu_req,
   input  logic                               cpu_we,
   input  logic [TAG_LENGTH+INDEX_LENGTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0]              cpu_wdata,
   output logic                               cpu_ready,
   output logic                               cpu_hit,
   output logic [DATA_WIDTH-1:0]              cpu_rdata,
   output logic                               tag_write,
   output logic [INDEX_LENGTH-1:0]            tag_index,
   output logic [TAG_LENGTH-1:0]              tag_wdata,
   input  logic [TAG_LENGTH-1:0]              tag_rdata,
   output logic                               data_write,
   output logic [DATA_WIDTH-1:0]              data_wdata,
   input  logic [DATA_WIDTH-1:0]              data_rdata,
   output logic                               mem_req,
   output logic                               mem_we,
   output logic [TAG_LENGTH+INDEX_LENGTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]              mem_wdata,
   input  logic                               mem_ack,
   input  logic [DATA_WIDTH-1:0]              mem_rdata,
   output logic [15:0]                        hit_count,
   output logic [15:0]                        miss_count
);

   localparam int ADDR_WIDTH = TAG_LENGTH + INDEX_LENGTH;
   localparam int LINES      = 1 << INDEX_LENGTH;

   typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, MEM_WR, RESP} state_t;

   state_t                  state_reg;
   logic                    we_reg;
   logic [ADDR_WIDTH-1:0]   addr_reg;
   logic [DATA_WIDTH-1:0]   wdata_reg;
   logic [LINES-1:0]        valid_reg;
   logic                    lookup_hit_reg;

   logic [TAG_LENGTH-1:0]   addr_tag;
   logic [INDEX_LENGTH-1:0] addr_index;
   logic                    lookup_hit;
   logic                    accept;
   logic                    refill;

   assign addr_tag   = addr_reg[ADDR_WIDTH-1:INDEX_LENGTH];
   assign addr_index = addr_reg[INDEX_LENGTH-1:0];
   assign lookup_hit = valid_reg[addr_index] && (tag_rdata == addr_tag);
   assign accept     = (state_reg == IDLE) && cpu_req;
   assign refill     = (state_reg == MEM_RD) && mem_ack;

   // The arrays have a registered read, so the index is presented straight from the
   // request in the accept cycle; the lookup data is then valid in LOOKUP.
   assign tag_index  = (accept && resetn) ? cpu_addr[INDEX_LENGTH-1:0] : addr_index;
   assign tag_write  = refill;
   assign tag_wdata  = addr_tag;
   assign data_write = refill || ((state_reg == LOOKUP) && we_reg && lookup_hit);
   assign data_wdata = (state_reg == MEM_RD) ? mem_rdata : wdata_reg;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg      <= IDLE;
         we_reg         <= 1'b0;
         addr_reg       <= '0;
         wdata_reg      <= '0;
         valid_reg      <= '0;
         lookup_hit_reg <= 1'b0;
         cpu_ready      <= 1'b0;
         cpu_hit        <= 1'b0;
         cpu_rdata      <= '0;
         mem_req        <= 1'b0;
         mem_we         <= 1'b0;
         mem_addr       <= '0;
         mem_wdata      <= '0;
      end else begin
         cpu_ready <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (cpu_req) begin
                  we_reg    <= cpu_we;
                  addr_reg  <= cpu_addr;
                  wdata_reg <= cpu_wdata;
                  state_reg <= LOOKUP;
               end
            end
            LOOKUP: begin
               lookup_hit_reg <= lookup_hit;
               if (!we_reg && lookup_hit) begin
                  cpu_ready <= 1'b1;
                  cpu_hit   <= 1'b1;
                  cpu_rdata <= data_rdata;
                  state_reg <= RESP;
               end else begin
                  // Writes always go through to memory; the array was already updated on a hit.
                  mem_req   <= 1'b1;
                  mem_we    <= we_reg;
                  mem_addr  <= addr_reg;
                  mem_wdata <= wdata_reg;
                  state_reg <= we_reg ? MEM_WR : MEM_RD;
               end
            end
            MEM_RD: begin
               if (mem_ack) begin
                  valid_reg[addr_index] <= 1'b1;
                  cpu_ready <= 1'b1;
                  cpu_hit   <= 1'b0;
                  cpu_rdata <= mem_rdata;
                  mem_req   <= 1'b0;
                  state_reg <= RESP;
               end
            end
            MEM_WR: begin
               if (mem_ack) begin
                  cpu_ready <= 1'b1;
                  cpu_hit   <= lookup_hit_reg;
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  state_reg <= RESP;
               end
            end
            RESP: begin
               cpu_hit   <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

`ifdef CACHE_STATS_EN
   logic [15:0] hit_count_reg;
   logic [15:0] miss_count_reg;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hit_count_reg  <= '0;
         miss_count_reg <= '0;
      end else if (state_reg == RESP) begin
         if (cpu_hit) begin
            if (hit_count_reg != 16'hFFFF) hit_count_reg <= hit_count_reg + 16'd1;
         end else begin
            if (miss_count_reg != 16'hFFFF) miss_count_reg <= miss_count_reg + 16'd1;
         end
      end
   end

   assign hit_count  = hit_count_reg;
   assign miss_count = miss_count_reg;
`else
   assign hit_count  = '0;
   assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed, table-driven bench for cache_ctrl with behavioural tag/data arrays and a main-memory responder.
module tb_cache_ctrl;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [15:0] cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic        cpu_ready;
   logic        cpu_hit;
   logic [31:0] cpu_rdata;
   logic        tag_write;
   logic [5:0]  tag_index;
   logic [9:0]  tag_wdata;
   logic [9:0]  tag_rdata = '0;
   logic        data_write;
   logic [31:0] data_wdata;
   logic [31:0] data_rdata = '0;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic [15:0] hit_count;
   logic [15:0] miss_count;

   int checks = 0;
   int errors = 0;

   cache_ctrl #(.TAG_LENGTH(10), .INDEX_LENGTH(6), .DATA_WIDTH(32)) dut (
      .clk(clk), .resetn(resetn),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ready(cpu_ready), .cpu_hit(cpu_hit), .cpu_rdata(cpu_rdata),
      .tag_write(tag_write), .tag_index(tag_index), .tag_wdata(tag_wdata), .tag_rdata(tag_rdata),
      .data_write(data_write), .data_wdata(data_wdata), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   // Tag and data arrays with a one-cycle registered read.
   logic [9:0]  tag_mem [64] = '{default: '0};
   logic [31:0] dat_mem [64] = '{default: '0};
   always @(posedge clk) begin
      if (tag_write)  tag_mem[tag_index] <= tag_wdata;
      if (data_write) dat_mem[tag_index] <= data_wdata;
      tag_rdata  <= tag_mem[tag_index];
      data_rdata <= dat_mem[tag_index];
   end

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic [31:0] mrdata;
      int          delay;
      logic        exp_hit;
      logic [31:0] exp_rdata;
      logic        exp_mem;
      logic        exp_tag_wr;
      logic        exp_data_wr;
      logic [31:0] exp_data_wdata;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic run_txn(input string tag, input vec_t v);
      int          ready_n = -1;
      int          req_cycles = 0;
      int          tw_n = -1;
      int          dw_n = -1;
      int          exp_ready;
      logic        saw_req = 1'b0;
      logic        unstable = 1'b0;
      logic        first_we = 1'b0;
      logic [15:0] first_addr = '0;
      logic [31:0] first_wdata = '0;
      logic [9:0]  tw_data = '0;
      logic [5:0]  tw_idx = '0;
      logic [31:0] dw_data = '0;
      logic [5:0]  dw_idx = '0;
      logic        hit = 1'b0;
      logic [31:0] rdata = '0;

      @(negedge clk);
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
      #1;
      check({tag, "_idle_tag_index"}, 64'(tag_index), 64'(v.addr[5:0]));
      @(posedge clk);
      #1;
      cpu_req = 1'b0; cpu_we = ~v.we; cpu_addr = ~v.addr; cpu_wdata = ~v.wdata;

      for (int n = 0; n < 60 && ready_n < 0; n++) begin
         @(negedge clk);
         mem_ack   = (n == 0);  // stray ack while no memory request is outstanding
         mem_rdata = ~v.mrdata;
         if (mem_req) begin
            if (!saw_req) begin
               saw_req = 1'b1; first_we = mem_we; first_addr = mem_addr; first_wdata = mem_wdata;
            end else if (mem_we !== first_we || mem_addr !== first_addr || mem_wdata !== first_wdata) begin
               unstable = 1'b1;
            end
            if (req_cycles >= v.delay) begin
               mem_ack = 1'b1; mem_rdata = v.mrdata;
            end
            req_cycles++;
         end
         #1;
         if (tag_write && tw_n < 0)  begin tw_n = n; tw_data = tag_wdata; tw_idx = tag_index; end
         if (data_write && dw_n < 0) begin dw_n = n; dw_data = data_wdata; dw_idx = tag_index; end
         if (cpu_ready) begin ready_n = n; hit = cpu_hit; rdata = cpu_rdata; end
      end
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      check({tag, "_ready_one_cycle"}, 64'(cpu_ready), 64'(0));

      exp_ready = (v.exp_hit && !v.we) ? 2 : v.delay + 3;
      $display("txn %s we=%0d addr=%h ready_cycle=%0d hit=%0d rdata=%h mem=%0d tag_wr=%0d data_wr=%0d",
               tag, v.we, v.addr, ready_n + 1, hit, rdata, saw_req, tw_n >= 0, dw_n >= 0);

      check({tag, "_ready_cycle"}, 64'(ready_n + 1), 64'(exp_ready));
      check({tag, "_hit"}, 64'(hit), 64'(v.exp_hit));
      if (!v.we) check({tag, "_rdata"}, 64'(rdata), 64'(v.exp_rdata));
      check({tag, "_mem_req"}, 64'(saw_req), 64'(v.exp_mem));
      if (v.exp_mem) begin
         check({tag, "_mem_we"}, 64'(first_we), 64'(v.we));
         check({tag, "_mem_addr"}, 64'(first_addr), 64'(v.addr));
         check({tag, "_mem_stable"}, 64'(unstable), 64'(0));
         if (v.we) check({tag, "_mem_wdata"}, 64'(first_wdata), 64'(v.wdata));
      end
      check({tag, "_tag_write"}, 64'(tw_n >= 0), 64'(v.exp_tag_wr));
      if (v.exp_tag_wr) begin
         check({tag, "_tag_wr_cycle"}, 64'(tw_n), 64'(v.delay + 1));
         check({tag, "_tag_wdata"}, 64'(tw_data), 64'(v.addr[15:6]));
         check({tag, "_tag_wr_index"}, 64'(tw_idx), 64'(v.addr[5:0]));
      end
      check({tag, "_data_write"}, 64'(dw_n >= 0), 64'(v.exp_data_wr));
      if (v.exp_data_wr) begin
         check({tag, "_data_wr_cycle"}, 64'(dw_n), 64'(v.we ? 0 : v.delay + 1));
         check({tag, "_data_wdata"}, 64'(dw_data), 64'(v.exp_data_wdata));
         check({tag, "_data_wr_index"}, 64'(dw_idx), 64'(v.addr[5:0]));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t vecs [6];
      vec_t post [3];
      logic seen;
      logic stray;
      logic [15:0] exp_hits;
      logic [15:0] exp_misses;

      // we, addr, wdata, mem_rdata, ack delay, hit, rdata, mem access, tag_write, data_write, data_wdata
      vecs[0] = '{1'b0, 16'h0281, 32'h0,        32'hDEADBEEF, 3, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF};
      vecs[1] = '{1'b0, 16'h0281, 32'h0,        32'h11111111, 0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0};
      vecs[2] = '{1'b0, 16'h03C1, 32'h0,        32'hA5A50001, 1, 1'b0, 32'hA5A50001, 1'b1, 1'b1, 1'b1, 32'hA5A50001};
      vecs[3] = '{1'b1, 16'h03C1, 32'h12345678, 32'h0,        2, 1'b1, 32'h0,        1'b1, 1'b0, 1'b1, 32'h12345678};
      vecs[4] = '{1'b0, 16'h0281, 32'h0,        32'h0BADF00D, 0, 1'b0, 32'h0BADF00D, 1'b1, 1'b1, 1'b1, 32'h0BADF00D};
      vecs[5] = '{1'b1, 16'h0002, 32'hCAFEF00D, 32'h0,        4, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0};

      post[0] = '{1'b0, 16'h03C1, 32'h0,        32'h55AA55AA, 1, 1'b0, 32'h55AA55AA, 1'b1, 1'b1, 1'b1, 32'h55AA55AA};
      post[1] = '{1'b0, 16'h03C1, 32'h0,        32'h0,        0, 1'b1, 32'h55AA55AA, 1'b0, 1'b0, 1'b0, 32'h0};
      post[2] = '{1'b0, 16'h03C1, 32'h0,        32'h77778888, 2, 1'b0, 32'h77778888, 1'b1, 1'b1, 1'b1, 32'h77778888};

      // Reset state
      #12;
      check("rst_cpu_ready",  64'(cpu_ready),  64'(0));
      check("rst_cpu_hit",    64'(cpu_hit),    64'(0));
      check("rst_cpu_rdata",  64'(cpu_rdata),  64'(0));
      check("rst_tag_write",  64'(tag_write),  64'(0));
      check("rst_data_write", 64'(data_write), 64'(0));
      check("rst_tag_index",  64'(tag_index),  64'(0));
      check("rst_tag_wdata",  64'(tag_wdata),  64'(0));
      check("rst_data_wdata", 64'(data_wdata), 64'(0));
      check("rst_mem_req",    64'(mem_req),    64'(0));
      check("rst_mem_we",     64'(mem_we),     64'(0));
      check("rst_mem_addr",   64'(mem_addr),   64'(0));
      check("rst_mem_wdata",  64'(mem_wdata),  64'(0));
      check("rst_hit_count",  64'(hit_count),  64'(0));
      check("rst_miss_count", 64'(miss_count), 64'(0));
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) run_txn($sformatf("v%0d", i), vecs[i]);

`ifdef CACHE_STATS_EN
      exp_hits = 16'd2; exp_misses = 16'd4;
`else
      exp_hits = 16'd0; exp_misses = 16'd0;
`endif
      check("stats_hit_count",  64'(hit_count),  64'(exp_hits));
      check("stats_miss_count", 64'(miss_count), 64'(exp_misses));

      // Make 0x3C1 resident and confirm it hits
      run_txn("p0", post[0]);
      run_txn("p1", post[1]);

      // Reset while MEM_RD waits for an acknowledge
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0002;
      @(posedge clk);
      #1;
      cpu_req = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         seen = mem_req;
      end
      check("rstmid_req_up", 64'(seen), 64'(1));
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b0;
      #1;
      check("rstmid_mem_req_drop", 64'(mem_req), 64'(0));
      check("rstmid_ready_low", 64'(cpu_ready), 64'(0));
      check("rstmid_hit_count", 64'(hit_count), 64'(0));
      @(negedge clk);
      mem_ack = 1'b1;
      @(negedge clk);
      resetn = 1'b1;
      stray = 1'b0;
      for (int k = 0; k < 6; k++) begin
         mem_ack = (k < 3);
         @(negedge clk);
         #1;
         stray = stray | cpu_ready | mem_req;
      end
      mem_ack = 1'b0;
      check("rstmid_no_ready_no_req", 64'(stray), 64'(0));

      // Tag 15 is still in the array at index 1, but the valid bit was cleared
      run_txn("p2", post[2]);

`ifdef CACHE_STATS_EN
      exp_misses = 16'd1;
`else
      exp_misses = 16'd0;
`endif
      check("post_rst_hit_count",  64'(hit_count),  64'(0));
      check("post_rst_miss_count", 64'(miss_count), 64'(exp_misses));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- TAG_LENGTH, 10, tag width.
- INDEX_LENGTH, 6, index width; the cache holds 2^INDEX_LENGTH one-word lines.
- DATA_WIDTH, 32, word width.
REQ-002 Ports (name  direction  width  meaning), one per line; ADDR = TAG_LENGTH+INDEX_LENGTH, with address = {tag, index}:
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- cpu_req  in  1  request valid, sampled in IDLE only.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR  word address.
- cpu_wdata  in  DATA_WIDTH  write data.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_hit  out  1  hit flag, valid while cpu_ready is high.
- cpu_rdata  out  DATA_WIDTH  read data, valid while cpu_ready is high.
- tag_write  out  1  tag memory write strobe.
- tag_index  out  INDEX_LENGTH  tag/data array index.
- tag_wdata  out  TAG_LENGTH  tag to store.
- tag_rdata  in  TAG_LENGTH  tag memory read data, registered (valid one cycle after tag_index is presented).
- data_write  out  1  data array write strobe, same index as tag_index.
- data_wdata  out  DATA_WIDTH  data array write data.
- data_rdata  in  DATA_WIDTH  data array read data, same one-cycle timing as tag_rdata.
- mem_req  out  1  main-memory request.
- mem_we  out  1  main-memory write.
- mem_addr  out  ADDR  main-memory address.
- mem_wdata  out  DATA_WIDTH  main-memory write data.
- mem_ack  in  1  main-memory completion, single cycle.
- mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ack.
- hit_count  out  16  statistics.
- miss_count  out  16  statistics.

Function
REQ-003 The block SHALL hold an internal valid bit per index.
- Lookup hit = valid[index] AND (tag_rdata == tag).
REQ-004 FSM states SHALL be IDLE, LOOKUP, MEM_RD, MEM_WR, RESP.
REQ-005 IDLE: cpu_req=1 SHALL latch cpu_we, cpu_addr and cpu_wdata, drive tag_index = index, and go to LOOKUP.
- cpu_req in any other state SHALL be ignored.
REQ-006 LOOKUP, by case:
- Read hit: capture data_rdata, hit=1, go to RESP.
- Read miss: go to MEM_RD.
- Write hit: pulse data_write with the latched wdata, go to MEM_WR.
- Write miss: go to MEM_WR with no array write (write-through, no-write-allocate).
REQ-007 MEM_RD: hold mem_req=1, mem_we=0, mem_addr=latched address until mem_ack=1 is sampled.
- In that same cycle, pulse tag_write (tag_wdata = latched tag) and data_write (data_wdata = mem_rdata).
- Set valid[index], capture mem_rdata, hit=0, go to RESP.
REQ-008 MEM_WR: hold mem_req=1, mem_we=1, mem_addr and mem_wdata stable until mem_ack; then go to RESP.
REQ-009 RESP: assert cpu_ready for exactly one cycle with cpu_hit and cpu_rdata, then go to IDLE.
- cpu_rdata is don't-care for writes.
REQ-010 Latency:
- Read hit: cpu_ready SHALL assert in the second cycle after the accept edge.
- Miss or write: cpu_ready SHALL assert in the cycle after mem_ack.
REQ-011 mem_ack while mem_req=0 SHALL be ignored.
- All request outputs SHALL stay stable while waiting, with no timeout.
REQ-012 tag_write and data_write SHALL never assert outside the cases in REQ-006 and REQ-007.
REQ-013 A same-index conflict miss SHALL overwrite the old tag; no eviction write-back is needed because the cache is write-through.

Reset
REQ-014 While resetn=0, all state SHALL be cleared:
- FSM = IDLE.
- All valid bits = 0.
- cpu_ready, cpu_hit, tag_write, data_write, mem_req, mem_we = 0.
- Address and data outputs = 0.
- Counters = 0.
REQ-015 Reset asserted mid-transaction SHALL drop mem_req immediately, abandon the request, and issue no cpu_ready.

Configuration
REQ-016 Macro CACHE_STATS_EN:
- When defined: hit_count and miss_count each increment by 1 in the RESP cycle of a hit or miss respectively, and saturate at 0xFFFF.
- When undefined: both ports exist and are tied to 0, and no counter logic is instantiated.

Verification
REQ-017 After reset, read addr 0x281 (tag 10, index 1) -> mem_req=1, mem_we=0, mem_addr=0x281; mem_ack after 3 cycles with rdata 0xDEADBEEF -> tag_write index 1 tag 10, cpu_ready with cpu_rdata 0xDEADBEEF, cpu_hit=0.
REQ-018 Read 0x281 again with data_rdata=0xDEADBEEF -> no mem_req, cpu_ready in the second cycle after accept, cpu_hit=1, cpu_rdata 0xDEADBEEF.
REQ-019 Read 0x3C1 (tag 15, index 1) -> miss, refill with tag_wdata=15; a following read of 0x281 misses.
REQ-020 Write 0x12345678 to 0x3C1 -> data_write in LOOKUP, then mem_req=1, mem_we=1, mem_wdata 0x12345678; cpu_hit=1 after ack. Write to 0x002 -> mem write only, no tag_write or data_write.
REQ-021 resetn pulsed low while MEM_RD waits for ack -> mem_req=0 immediately, no cpu_ready; a later read of 0x3C1 misses.
REQ-022 With CACHE_STATS_EN defined, after REQ-017 through REQ-020 -> hit_count=2, miss_count=4; without the macro both read 0.
